ultrasonic_scheduler: RTL and testbench
=======================================

# ultrasonic_scheduler

Round-robin scheduler that shares a single echo-timing datapath among N ultrasonic rangers (HC-SR04 class) on the robot. It fires one sensor at a time so that adjacent sensors do not crosstalk: inter-ping gap, trigger pulse, then echo measurement with timeout. Each result is emitted as raw echo-width clock cycles with a valid/ready handshake, and feeds the distance-to-ASCII formatter and the obstacle logic.

## Interface
- N_SENSORS, 4 — number of rangers scheduled (1..8).
- TRIG_CYCLES, 500 — trigger high time in clk cycles (10 µs at 50 MHz).
- GAP_CYCLES, 3_000_000 — quiet time before each ping (60 ms).
- TIMEOUT_CYCLES, 1_500_000 — maximum wait for echo rise, and maximum echo width (30 ms).
- CNT_W, 22 — width of the cycle counters and of result_cycles; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; 1 = scan continuously, 0 = stop after the current result.
- echo  in  N_SENSORS  raw echo pins (asynchronous).
- trig  out  N_SENSORS  trigger pins; at most one bit high at any time.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts the result.
- result_id  out  3  index of the sensor that produced the result.
- result_cycles  out  CNT_W  echo high time in cycles; all ones on timeout.
- result_timeout  out  1  no echo, or echo exceeded TIMEOUT_CYCLES.

## Operation
- Reset (asynchronous, immediate): state IDLE; sensor index 0; all counters 0. All outputs are 0: trig, busy, result_valid, result_id, result_cycles and result_timeout.
- The echo inputs pass through 2-flop synchronizers. Rise and fall are detected on the synchronized signal.
- FSM states: IDLE, GAP, TRIG, WAIT_RISE, MEASURE, REPORT.
  - IDLE: if start=1, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to TRIG.
  - TRIG: trig[idx]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
  - WAIT_RISE: wait for a synchronized rising edge of echo[idx], then go to MEASURE with count=1. If TIMEOUT_CYCLES cycles pass first, go to REPORT with timeout=1.
  - MEASURE: count +1 each cycle that synchronized echo is high. On a falling edge, go to REPORT. If count reaches TIMEOUT_CYCLES, go to REPORT with timeout=1.
  - REPORT: result_valid=1, and the outputs are held stable until result_valid && result_ready. On that cycle: idx advances to (idx+1) mod N_SENSORS, then go to GAP if start=1, else IDLE.
- Backpressure stalls the scheduler: no new ping is issued while a result is unaccepted.
- An echo already high on entry to WAIT_RISE is not a rise; a stuck-high echo ends in timeout.
- Deasserting start mid-scan does not abort: the current measurement completes and is reported.
- Echo activity on non-selected sensors is ignored.
- Counters saturate; they never wrap.

## Timing
- trig[idx] rises on the first clock edge in TRIG; it is high for exactly TRIG_CYCLES cycles.
- Pin-to-decision latency is 3 cycles: 2 synchronizer cycles plus 1 edge-detect cycle.
- For a clean echo pulse of W cycles (W < TIMEOUT_CYCLES), result_cycles = W exactly.
- result_valid rises 1 cycle after the synchronized fall is detected.
- Handshake: a transfer occurs on a clock edge with result_valid && result_ready. result_valid drops on the next cycle.
- Minimum ping period per sensor: N_SENSORS × (GAP_CYCLES + TRIG_CYCLES + echo time + 4).

## Configuration
- ULTRA_SENSOR_MASK_EN defined:
  - Adds the input sensor_mask [N_SENSORS-1:0]; 1 = sensor enabled.
  - Index advance skips masked sensors, round robin from idx+1.
  - In IDLE, or when leaving REPORT, an all-zero mask keeps the block in IDLE with busy=0.
  - A mask change during a measurement takes effect only at the next index advance.
- Not defined: no sensor_mask port; all sensors are scanned in order 0..N_SENSORS-1.

## Structure
- Package ultra_pkg holds:
  - the FSM state enum;
  - the default constants (TRIG_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) at 50 MHz;
  - the localparam for the all-ones timeout value.
- Sub-module echo_sync is instantiated once per sensor: a 2-flop synchronizer plus registered rise/fall pulse outputs.
- The shared counter, index register and FSM stay in the top.

## Test plan
Bench parameters: N=2, TRIG=5, GAP=10, TIMEOUT=100, ready=1.
- start=1; echo[0] pulse of 37 cycles after the trigger → trig[0] high 5 cycles; result id=0, cycles=37, timeout=0; then trig[1] fires after the gap.
- No echo on sensor 1 → result id=1, cycles=all ones, timeout=1, 100 cycles after trig falls.
- Echo held high 150 cycles → timeout=1 when count reaches 100; the next ping still goes to the following sensor.
- ready=0 for 50 cycles during REPORT → valid and data stable throughout, trig stays 0; transfer happens when ready=1.
- rst pulse mid-MEASURE → trig, valid and busy drop immediately; after release the scan restarts at sensor 0.
- With ULTRA_SENSOR_MASK_EN and mask=2'b10 → only sensor 1 is triggered; mask=0 → IDLE with busy=0.

Source files
------------

// File: rtl/ultra_pkg.sv
// ultra_pkg: state encoding and 50 MHz default timing shared by
// the ultrasonic ranger scheduler and its echo synchronizers.
package ultra_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_REPORT
  } state_t;

  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int GAP_CYCLES_DEF     = 3_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 1_500_000;
  localparam int CNT_W_DEF          = 22;

  // Truncated to the counter width to form the timeout result code.
  localparam logic [31:0] ALL_ONES = '1;

endpackage

// File: rtl/echo_sync.sv
// echo_sync: 2-flop synchronizer for one raw echo pin with
// registered single-cycle rise and fall pulses.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_echo,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_echo;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin gap/trigger/echo timing over N rangers.
// ULTRA_SENSOR_MASK_EN adds sensor_mask to skip disabled rangers.
module ultrasonic_scheduler
  import ultra_pkg::*;
#(
  parameter int N_SENSORS      = 4,
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 busy,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [2:0]           result_id,
  output logic [CNT_W-1:0]     result_cycles,
  output logic                 result_timeout
`ifdef ULTRA_SENSOR_MASK_EN
  ,
  input  logic [N_SENSORS-1:0] sensor_mask
`endif
);

  localparam logic [CNT_W-1:0] L_GAP  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TRIG = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TO   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_ALL  = CNT_W'(ALL_ONES);

  state_t               r_state;
  state_t               w_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx;
  logic [2:0]           w_inc;
  logic [2:0]           w_adv;
  logic                 w_load;
  logic                 w_tout;
  logic                 w_any;
  logic [7:0]           w_mask8;
  logic [N_SENSORS-1:0] w_rise;
  logic [N_SENSORS-1:0] w_fall;
  logic [7:0]           w_rise8;
  logic [7:0]           w_fall8;
  logic [N_SENSORS-1:0] w_trig;
  logic [N_SENSORS-1:0] r_trig;
  logic                 r_busy;
  logic                 r_valid;
  logic [2:0]           r_res_id;
  logic [CNT_W-1:0]     r_res_cyc;
  logic                 r_res_to;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
    echo_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .i_echo (echo[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  assign w_rise8 = 8'(w_rise);
  assign w_fall8 = 8'(w_fall);

`ifdef ULTRA_SENSOR_MASK_EN
  assign w_mask8 = 8'(sensor_mask);
`else
  assign w_mask8 = 8'({N_SENSORS{1'b1}});
`endif

  assign w_any = |w_mask8;

  // First enabled sensor at or after s, wrapping at N_SENSORS.
  function automatic logic [2:0] f_pick(
    input logic [2:0] s,
    input logic [7:0] m
  );
    logic [2:0] r;
    logic [2:0] j;
    r = s;
    for (int k = N_SENSORS - 1; k >= 0; k--) begin
      j = 3'((int'(s) + k) % N_SENSORS);
      if (m[j]) r = j;
    end
    return r;
  endfunction

  assign w_inc = (r_idx == 3'(N_SENSORS - 1)) ? 3'd0 : r_idx + 3'd1;
  assign w_adv = f_pick(w_inc, w_mask8);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_load  = 1'b0;
    w_tout  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && w_any) begin
          w_state = S_GAP;
          w_cnt   = '0;
          w_idx   = f_pick(r_idx, w_mask8);
        end
      end
      S_GAP: begin
        if (r_cnt >= L_GAP) begin
          w_state = S_TRIG;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + L_ONE;
        end
      end
      S_TRIG: begin
        if (r_cnt >= L_TRIG) begin
          w_state = S_WAIT_RISE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + L_ONE;
        end
      end
      S_WAIT_RISE: begin
        if (w_rise8[r_idx]) begin
          w_state = S_MEASURE;
          w_cnt   = L_ONE;
        end else if (r_cnt >= L_TO) begin
          w_state = S_REPORT;
          w_load  = 1'b1;
          w_tout  = 1'b1;
        end else begin
          w_cnt = r_cnt + L_ONE;
        end
      end
      S_MEASURE: begin
        // Fall wins over the limit so a width just under it is exact.
        if (w_fall8[r_idx]) begin
          w_state = S_REPORT;
          w_load  = 1'b1;
        end else if (r_cnt >= L_TO) begin
          w_state = S_REPORT;
          w_load  = 1'b1;
          w_tout  = 1'b1;
        end else begin
          w_cnt = r_cnt + L_ONE;
        end
      end
      S_REPORT: begin
        if (r_valid && result_ready) begin
          w_idx   = w_adv;
          w_cnt   = '0;
          w_state = (start && w_any) ? S_GAP : S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_trig = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      w_trig[i] = (w_state == S_TRIG) && (w_idx == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_trig    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_res_id  <= '0;
      r_res_cyc <= '0;
      r_res_to  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_trig  <= w_trig;
      r_busy  <= (w_state != S_IDLE);
      r_valid <= (w_state == S_REPORT);
      if (w_load) begin
        r_res_id  <= r_idx;
        r_res_cyc <= w_tout ? L_ALL : r_cnt;
        r_res_to  <= w_tout;
      end
    end
  end

  assign trig           = r_trig;
  assign busy           = r_busy;
  assign result_valid   = r_valid;
  assign result_id      = r_res_id;
  assign result_cycles  = r_res_cyc;
  assign result_timeout = r_res_to;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// tb_ultrasonic_scheduler: directed vectors for the ranger scheduler
// with N=2, TRIG=5, GAP=10, TIMEOUT=100.
module tb_ultrasonic_scheduler;

  localparam logic [31:0] TO_VAL = 32'h003F_FFFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  echo;
  logic [1:0]  trig;
  logic        busy;
  logic        valid;
  logic        ready;
  logic [2:0]  rid;
  logic [21:0] rcyc;
  logic        rto;
`ifdef ULTRA_SENSOR_MASK_EN
  logic [1:0]  mask;
`endif

  int checks;
  int errors;

  ultrasonic_scheduler #(
    .N_SENSORS      (2),
    .TRIG_CYCLES    (5),
    .GAP_CYCLES     (10),
    .TIMEOUT_CYCLES (100),
    .CNT_W          (22)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .echo           (echo),
    .trig           (trig),
    .busy           (busy),
    .result_valid   (valid),
    .result_ready   (ready),
    .result_id      (rid),
    .result_cycles  (rcyc),
    .result_timeout (rto)
`ifdef ULTRA_SENSOR_MASK_EN
    ,
    .sensor_mask    (mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_trig(output int n);
    n = 0;
    while (trig == 2'b00 && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_trig_low(output int n);
    n = 0;
    while (trig != 2'b00 && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  int          n;
  int          lat;
  logic [21:0] cyc;
  logic        to;
  logic [1:0]  tg;
  logic        ok;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    echo   = 2'b00;
    ready  = 1'b1;
`ifdef ULTRA_SENSOR_MASK_EN
    mask   = 2'b11;
`endif
    tick(3);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_id", 32'(rid), 0);
    chk("rst_cyc", 32'(rcyc), 0);
    chk("rst_to", 32'(rto), 0);

    // sensor 0: clean 37-cycle echo
    rst   = 1'b0;
    start = 1'b1;
    wait_trig(n);
    chk("gap0", n, 11);
    chk("trig0", 32'(trig), 1);
    chk("busy0", 32'(busy), 1);
    wait_trig_low(n);
    chk("twidth0", n, 5);
    tick(2);
    echo[0] = 1'b1;
    tick(37);
    echo[0] = 1'b0;
    wait_valid(n);
    chk("fall2valid", n, 4);
    chk("id0", 32'(rid), 0);
    chk("cyc37", 32'(rcyc), 37);
    chk("to0", 32'(rto), 0);
    tick(1);
    chk("vdrop0", 32'(valid), 0);

    // sensor 1: no echo
    wait_trig(n);
    chk("gap1", n, 10);
    chk("trig1", 32'(trig), 2);
    wait_trig_low(n);
    chk("twidth1", n, 5);
    wait_valid(n);
    chk("norise_lat", n, 100);
    chk("norise_id", 32'(rid), 1);
    chk("norise_cyc", 32'(rcyc), TO_VAL);
    chk("norise_to", 32'(rto), 1);

    // sensor 0: echo held 150 cycles
    wait_trig(n);
    chk("gap2", n, 11);
    chk("trig2", 32'(trig), 1);
    wait_trig_low(n);
    echo[0] = 1'b1;
    lat = 0;
    tg  = 2'b00;
    cyc = '0;
    to  = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (valid && lat == 0) begin
        lat = k;
        cyc = rcyc;
        to  = rto;
      end
      if (trig != 2'b00 && tg == 2'b00) tg = trig;
    end
    echo[0] = 1'b0;
    chk("long_lat", lat, 103);
    chk("long_cyc", 32'(cyc), TO_VAL);
    chk("long_to", 32'(to), 1);
    chk("long_next", 32'(tg), 2);

    // sensor 1: 20-cycle echo under 50 cycles of backpressure
    ready   = 1'b0;
    echo[1] = 1'b1;
    tick(20);
    echo[1] = 1'b0;
    wait_valid(n);
    chk("bp_lat", n, 4);
    chk("bp_id", 32'(rid), 1);
    chk("bp_cyc", 32'(rcyc), 20);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!valid || rcyc != 22'd20 || rid != 3'd1 || rto) ok = 1'b0;
      if (trig != 2'b00 || !busy) ok = 1'b0;
    end
    chk("bp_stable", 32'(ok), 1);
    ready = 1'b1;
    tick(1);
    chk("bp_drop", 32'(valid), 0);
    wait_trig(n);
    chk("bp_gap", n, 10);
    chk("bp_next", 32'(trig), 1);

    // reset in the middle of a measurement
    wait_trig_low(n);
    tick(2);
    echo[0] = 1'b1;
    tick(10);
    chk("meas_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_trig", 32'(trig), 0);
    @(negedge clk);
    echo = 2'b00;
    rst  = 1'b0;
    wait_trig(n);
    chk("arst_gap", n, 11);
    chk("arst_idx", 32'(trig), 1);

    // dropping start finishes the current ping then idles
    start = 1'b0;
    wait_trig_low(n);
    tick(2);
    echo[0] = 1'b1;
    tick(10);
    echo[0] = 1'b0;
    wait_valid(n);
    chk("stop_lat", n, 4);
    chk("stop_cyc", 32'(rcyc), 10);
    ok = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (trig != 2'b00) ok = 1'b1;
    end
    chk("stop_trig", 32'(ok), 0);
    chk("stop_busy", 32'(busy), 0);

`ifdef ULTRA_SENSOR_MASK_EN
    rst  = 1'b1;
    tick(2);
    mask  = 2'b10;
    rst   = 1'b0;
    start = 1'b1;
    wait_trig(n);
    chk("mask_gap", n, 11);
    chk("mask_trig0", 32'(trig), 2);
    wait_trig_low(n);
    wait_valid(n);
    chk("mask_id0", 32'(rid), 1);
    wait_trig(n);
    chk("mask_trig1", 32'(trig), 2);
    mask = 2'b00;
    wait_trig_low(n);
    wait_valid(n);
    chk("mask_id1", 32'(rid), 1);
    tick(2);
    chk("mask0_busy", 32'(busy), 0);
    ok = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (trig != 2'b00 || busy) ok = 1'b1;
    end
    chk("mask0_idle", 32'(ok), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
